// File: rtl/generic_sram_byte_en_arb2.sv
// Round-robin arbiter sharing one byte-enabled single-port SRAM (1-cycle registered read)
// between two requesters; read results are steered back to the requester that issued them.
module generic_sram_byte_en_arb2 #(
  parameter int MEM_ADDR_BITS = 10,
  parameter int MEM_DATA_BITS = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_0,
  input  logic                         i_write_en_0,
  input  logic [MEM_ADDR_BITS-1:0]     i_addr_0,
  input  logic [MEM_DATA_BITS-1:0]     i_write_data_0,
  input  logic [MEM_DATA_BITS/8-1:0]   i_byte_en_0,
  output logic                         o_gnt_0,
  output logic                         o_rvalid_0,
  output logic [MEM_DATA_BITS-1:0]     o_read_data_0,
  input  logic                         i_req_1,
  input  logic                         i_write_en_1,
  input  logic [MEM_ADDR_BITS-1:0]     i_addr_1,
  input  logic [MEM_DATA_BITS-1:0]     i_write_data_1,
  input  logic [MEM_DATA_BITS/8-1:0]   i_byte_en_1,
  output logic                         o_gnt_1,
  output logic                         o_rvalid_1,
  output logic [MEM_DATA_BITS-1:0]     o_read_data_1,
  output logic [MEM_ADDR_BITS-1:0]     o_sram_addr,
  output logic                         o_sram_write_en,
  output logic [MEM_DATA_BITS-1:0]     o_sram_write_data,
  output logic [MEM_DATA_BITS/8-1:0]   o_sram_byte_en,
  input  logic [MEM_DATA_BITS-1:0]     i_sram_read_data
);
  localparam int BE_BITS = MEM_DATA_BITS / 8;

  logic                     r_last_winner;
  logic                     r_rd_pending_0, r_rd_pending_1;
  logic [MEM_DATA_BITS-1:0] r_hold_0, r_hold_1;
  logic                     w_gnt_0, w_gnt_1;

  // A contested cycle goes to whoever did not win last; reset leaves 1 so requester 0 wins first.
  assign w_gnt_0 = ~i_rst & i_req_0 & (~i_req_1 | r_last_winner);
  assign w_gnt_1 = ~i_rst & i_req_1 & (~i_req_0 | ~r_last_winner);

  always_comb begin
    o_sram_addr       = '0;
    o_sram_write_en   = 1'b0;
    o_sram_write_data = '0;
    o_sram_byte_en    = '0;
    if (w_gnt_0) begin
      o_sram_addr       = i_addr_0;
      o_sram_write_en   = i_write_en_0;
      o_sram_write_data = i_write_data_0;
      o_sram_byte_en    = i_byte_en_0;
    end else if (w_gnt_1) begin
      o_sram_addr       = i_addr_1;
      o_sram_write_en   = i_write_en_1;
      o_sram_write_data = i_write_data_1;
      o_sram_byte_en    = i_byte_en_1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_winner  <= 1'b1;
      r_rd_pending_0 <= 1'b0;
      r_rd_pending_1 <= 1'b0;
      r_hold_0       <= '0;
      r_hold_1       <= '0;
    end else begin
      if (w_gnt_0)      r_last_winner <= 1'b0;
      else if (w_gnt_1) r_last_winner <= 1'b1;
      r_rd_pending_0 <= w_gnt_0 & ~i_write_en_0;
      r_rd_pending_1 <= w_gnt_1 & ~i_write_en_1;
      // Keep the last result visible after the rvalid pulse.
      if (r_rd_pending_0) r_hold_0 <= i_sram_read_data;
      if (r_rd_pending_1) r_hold_1 <= i_sram_read_data;
    end
  end

  assign o_gnt_0       = w_gnt_0;
  assign o_gnt_1       = w_gnt_1;
  assign o_rvalid_0    = r_rd_pending_0;
  assign o_rvalid_1    = r_rd_pending_1;
  assign o_read_data_0 = r_rd_pending_0 ? i_sram_read_data : r_hold_0;
  assign o_read_data_1 = r_rd_pending_1 ? i_sram_read_data : r_hold_1;

  if (BE_BITS * 8 != MEM_DATA_BITS) begin : g_bad_width
    $error("MEM_DATA_BITS must be a multiple of 8");
  end
endmodule

// File: tb/tb_generic_sram_byte_en_arb2.sv
// Scoreboard bench: driver checks grants/SRAM drive and queues expected reads; monitor checks returns.
module tb_generic_sram_byte_en_arb2;
  localparam int AW = 10, DW = 32, BW = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wd0, wd1;
  logic [BW-1:0] be0, be1;
  logic          gnt0, gnt1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [DW-1:0] s_wd, s_rd;
  logic [BW-1:0] s_be;

  generic_sram_byte_en_arb2 #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_0(req0), .i_write_en_0(we0), .i_addr_0(addr0), .i_write_data_0(wd0), .i_byte_en_0(be0),
    .o_gnt_0(gnt0), .o_rvalid_0(rv0), .o_read_data_0(rd0),
    .i_req_1(req1), .i_write_en_1(we1), .i_addr_1(addr1), .i_write_data_1(wd1), .i_byte_en_1(be1),
    .o_gnt_1(gnt1), .o_rvalid_1(rv1), .o_read_data_1(rd1),
    .o_sram_addr(s_addr), .o_sram_write_en(s_we), .o_sram_write_data(s_wd), .o_sram_byte_en(s_be),
    .i_sram_read_data(s_rd)
  );

  // Behavioural byte-enabled SRAM with registered read (read-before-write).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (s_we)
      for (int k = 0; k < BW; k++)
        if (s_be[k]) mem[s_addr][8*k +: 8] <= s_wd[8*k +: 8];
    s_rd <= mem[s_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; int c; } exp_t;
  exp_t          q [2][$];
  logic [DW-1:0] last [2];
  int            n_cmp = 0, n_err = 0;
  logic          mon_en = 1'b0;
  logic          rv [2];
  logic [DW-1:0] rd [2];
  assign rv[0] = rv0; assign rv[1] = rv1;
  assign rd[0] = rd0; assign rd[1] = rd1;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        if (q[p].size() > 0 && q[p][0].c < cyc) begin
          n_cmp++; n_err++;
          $display("FAIL rvalid%0d_missing: no rvalid at cycle %0d, exp data %h", p, q[p][0].c, q[p][0].d);
          void'(q[p].pop_front());
        end
        n_cmp++;
        if (rv[p]) begin
          if (q[p].size() == 0) begin
            n_err++;
            $display("FAIL rvalid%0d_unexpected: cycle %0d data %h, none expected", p, cyc, rd[p]);
          end else begin
            exp_t e;
            e = q[p].pop_front();
            if (e.c != cyc || rd[p] !== e.d) begin
              n_err++;
              $display("FAIL read%0d: got %h at cycle %0d, exp %h at cycle %0d", p, rd[p], cyc, e.d, e.c);
            end
            last[p] = e.d;
          end
        end else if (rd[p] !== last[p]) begin
          n_err++;
          $display("FAIL hold%0d: cycle %0d read_data %h, exp %h", p, cyc, rd[p], last[p]);
        end
        if (rst) last[p] = '0;
      end
    end
  end

  task automatic set(input int p, input logic r, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [BW-1:0] b);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wd0 = d; be0 = b; end
    else        begin req1 = r; we1 = w; addr1 = a; wd1 = d; be1 = b; end
  endtask

  // One cycle: check grants and SRAM drive, queue any expected read return.
  task automatic step(input logic eg0, input logic eg1, input logic [DW-1:0] e0,
                      input logic [DW-1:0] e1, input string nm);
    logic [AW+DW+BW:0] exp_drv, got_drv;
    @(negedge clk);
    n_cmp++;
    if ({gnt1, gnt0} !== {eg1, eg0}) begin
      n_err++;
      $display("FAIL %s_gnt: cycle %0d got %b%b exp %b%b", nm, cyc, gnt1, gnt0, eg1, eg0);
    end
    if (eg0)      exp_drv = {addr0, we0, wd0, be0};
    else if (eg1) exp_drv = {addr1, we1, wd1, be1};
    else          exp_drv = '0;
    got_drv = {s_addr, s_we, s_wd, s_be};
    n_cmp++;
    if (got_drv !== exp_drv) begin
      n_err++;
      $display("FAIL %s_sram: cycle %0d got %h exp %h", nm, cyc, got_drv, exp_drv);
    end
    if (eg0 && !we0) q[0].push_back('{e0, cyc + 1});
    if (eg1 && !we1) q[1].push_back('{e1, cyc + 1});
    @(posedge clk); #1;
  endtask

  initial begin
    int i0, i1, w;
    for (int a = 0; a < (1 << AW); a++) mem[a] <= '0;
    for (int k = 0; k < 8; k++) begin
      mem[10'h100 + 10'(k)] <= 32'hA000_0100 + DW'(k);
      mem[10'h200 + 10'(k)] <= 32'hB000_0200 + DW'(k);
    end
    for (int k = 1; k <= 4; k++) mem[10'(k)] <= 32'hC0DE_0000 + DW'(k);
    mem[10'h3FF] <= 32'h1234_5678;
    last[0] = '0; last[1] = '0;

    rst = 1'b1;
    set(0, 0, 0, '0, '0, '0); set(1, 0, 0, '0, '0, '0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    step(0, 0, 0, 0, "in_reset");
    set(0, 1, 0, 10'h005, '0, '0); set(1, 1, 0, 10'h006, '0, '0);
    step(0, 0, 0, 0, "reset_blocks");
    set(0, 0, 0, '0, '0, '0); set(1, 0, 0, '0, '0, '0);
    rst = 1'b0;
    repeat (5) step(0, 0, 0, 0, "idle");

    // First contested cycle goes to 0; then byte-merged write and read-back.
    set(0, 1, 1, 10'h012, 32'hDEADBEEF, 4'hF); set(1, 1, 1, 10'h012, 32'h0000_00AA, 4'h1);
    step(1, 0, 0, 0, "first_contest");
    set(0, 0, 0, '0, '0, '0);
    step(0, 1, 0, 0, "wr_byte");
    set(1, 0, 0, '0, '0, '0); set(0, 1, 0, 10'h012, '0, '0);
    step(1, 0, 32'hDEADBEAA, 0, "rd_merge");
    set(0, 0, 0, '0, '0, '0);
    step(0, 0, 0, 0, "idle_a");

    // Full contention: last winner is 0, so 1 starts and grants alternate.
    i0 = 0; i1 = 0;
    for (int k = 0; k < 8; k++) begin
      w = (k % 2 == 0) ? 1 : 0;
      set(0, 1, 0, 10'h100 + 10'(i0), '0, '0);
      set(1, 1, 0, 10'h200 + 10'(i1), '0, '0);
      step(w == 0, w == 1, 32'hA000_0100 + DW'(i0), 32'hB000_0200 + DW'(i1), "alt");
      if (w == 0) i0++; else i1++;
    end
    set(0, 0, 0, '0, '0, '0); set(1, 0, 0, '0, '0, '0);
    step(0, 0, 0, 0, "idle_b");
    step(0, 0, 0, 0, "idle_c");

    for (int k = 1; k <= 4; k++) begin
      set(1, 1, 0, 10'(k), '0, '0);
      step(0, 1, 0, 32'hC0DE_0000 + DW'(k), "b2b_rd1");
    end
    set(1, 0, 0, '0, '0, '0);
    step(0, 0, 0, 0, "idle_d");

    // Read in T, reset in T+1: data still returned, then everything clears.
    set(0, 1, 0, 10'h001, '0, '0);
    step(1, 0, 32'hC0DE_0001, 0, "rst_rd");
    rst = 1'b1;
    set(0, 1, 0, 10'h002, '0, '0); set(1, 1, 0, 10'h003, '0, '0);
    step(0, 0, 0, 0, "rst_mid");
    rst = 1'b0;
    set(0, 0, 0, '0, '0, '0); set(1, 0, 0, '0, '0, '0);
    step(0, 0, 0, 0, "post_rst");
    set(0, 1, 0, 10'h002, '0, '0); set(1, 1, 0, 10'h003, '0, '0);
    step(1, 0, 32'hC0DE_0002, 0, "post_rst_arb");
    set(0, 0, 0, '0, '0, '0);
    step(0, 1, 0, 32'hC0DE_0003, "post_rst_r1");
    set(1, 0, 0, '0, '0, '0);
    step(0, 0, 0, 0, "idle_e");

    // Zero byte-enable write is granted but changes nothing.
    set(0, 1, 1, 10'h3FF, 32'hFFFF_FFFF, 4'h0);
    step(1, 0, 0, 0, "wr_be0");
    set(0, 1, 0, 10'h3FF, '0, '0);
    step(1, 0, 32'h1234_5678, 0, "rd_be0");
    set(0, 0, 0, '0, '0, '0);
    repeat (3) step(0, 0, 0, 0, "drain");

    for (int p = 0; p < 2; p++) begin
      n_cmp++;
      if (q[p].size() != 0) begin
        n_err++;
        $display("FAIL drain%0d: %0d reads outstanding, exp 0", p, q[p].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
